// File: rtl/group_sequence_detect.sv
// group_sequence_detect: maskable serial pattern detector with grouped or sliding verdicts
//
// Parameters:
//   LEN     - pattern/group length in bits (2..32)
//   PATTERN - reset value of the pattern register; the MSB is compared against the first bit
//   MODE    - 0 = non-overlapping LEN-bit groups, 1 = overlapping sliding window
//   CNT_W   - width of the saturating statistics counters
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   data_valid   in   qualifies data
//   data         in   serial data bit
//   pattern_load in   loads pattern_in/mask_in and restarts the group/window
//   pattern_in   in   new pattern, MSB first
//   mask_in      in   per-position compare enable, 0 = don't care
//   match        out  one-cycle verdict pulse: pattern matched
//   not_match    out  one-cycle verdict pulse: pattern mismatched
//   match_cnt    out  saturating count of match pulses
//   verdict_cnt  out  saturating count of all verdicts
module group_sequence_detect #(
    parameter int LEN = 6,
    parameter logic [LEN-1:0] PATTERN = 6'b011100,
    parameter int MODE = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_valid,
    input  logic             data,
    input  logic             pattern_load,
    input  logic [LEN-1:0]   pattern_in,
    input  logic [LEN-1:0]   mask_in,
    output logic             match,
    output logic             not_match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] verdict_cnt
);
    localparam int PW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [PW-1:0] LAST = PW'(LEN - 1);

    typedef enum logic {S_FILL, S_STREAM} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    pos, pos_n;
    logic             flag, flag_n;
    logic [LEN-1:0]   shift, shift_n, shift_in;
    logic [LEN-1:0]   pat, pat_n, mask, mask_n;
    logic             match_n, not_match_n;
    logic [CNT_W-1:0] match_cnt_n, verdict_cnt_n;
    logic             verdict, hit, bit_mis;

    always_comb begin
        state_n       = state;
        pos_n         = pos;
        flag_n        = flag;
        shift_n       = shift;
        pat_n         = pat;
        mask_n        = mask;
        verdict       = 1'b0;
        hit           = 1'b0;
        shift_in      = {shift[LEN-2:0], data};
        // position p is compared against pattern bit LEN-1-p, so the MSB meets the first bit
        bit_mis       = (data ^ pat[LAST - pos]) & mask[LAST - pos];
        if (pattern_load) begin
            pat_n   = pattern_in;
            mask_n  = mask_in;
            pos_n   = '0;
            flag_n  = 1'b0;
            shift_n = '0;
            state_n = S_FILL;
        end else if (data_valid) begin
            if (MODE == 0) begin
                // the group always runs its full length; an early mismatch only sets the flag
                verdict = (pos == LAST);
                hit     = ~(flag | bit_mis);
                pos_n   = (pos == LAST) ? '0 : pos + 1'b1;
                flag_n  = (pos == LAST) ? 1'b0 : (flag | bit_mis);
            end else begin
                shift_n = shift_in;
                hit     = ((shift_in ^ pat) & mask) == '0;
                if (state == S_FILL) begin
                    verdict = (pos == LAST);
                    pos_n   = (pos == LAST) ? '0 : pos + 1'b1;
                    state_n = (pos == LAST) ? S_STREAM : S_FILL;
                end else begin
                    verdict = 1'b1;
                end
            end
        end
        match_n       = verdict & hit;
        not_match_n   = verdict & ~hit;
        match_cnt_n   = (match_n && !(&match_cnt)) ? match_cnt + 1'b1 : match_cnt;
        verdict_cnt_n = (verdict && !(&verdict_cnt)) ? verdict_cnt + 1'b1 : verdict_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FILL;
            pos         <= '0;
            flag        <= 1'b0;
            shift       <= '0;
            pat         <= PATTERN;
            mask        <= '1;
            match       <= 1'b0;
            not_match   <= 1'b0;
            match_cnt   <= '0;
            verdict_cnt <= '0;
        end else begin
            state       <= state_n;
            pos         <= pos_n;
            flag        <= flag_n;
            shift       <= shift_n;
            pat         <= pat_n;
            mask        <= mask_n;
            match       <= match_n;
            not_match   <= not_match_n;
            match_cnt   <= match_cnt_n;
            verdict_cnt <= verdict_cnt_n;
        end
    end
endmodule

// File: doc/group_sequence_detect.md
# group_sequence_detect

Parametrised serial sequence detector. It compares a valid-qualified 1-bit stream against a runtime-loadable, maskable LEN-bit pattern and issues one registered match/not_match verdict per group (grouped mode) or per accepted bit once the window is full (sliding mode). It also keeps saturating match and verdict counters. It replaces the fixed 6-bit grouped detector in the Nowcoder-Advanced sequence-detect family and sits directly after a serial bit source.

## Interface
Parameters:
- LEN, 6: pattern/group length in bits; legal range 2..32.
- PATTERN, 6'b011100: reset value of the pattern register, LEN bits. Bit LEN-1 is compared against the first bit received.
- MODE, 0: 0 = grouped, non-overlapping LEN-bit groups; 1 = sliding window, overlapping.
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_valid  in  1  qualifies data; a bit is accepted only on a cycle where this is 1.
- data  in  1  serial data bit.
- pattern_load  in  1  loads pattern_in/mask_in on this edge.
- pattern_in  in  LEN  new pattern; MSB is the first bit.
- mask_in  in  LEN  compare-enable per position; 0 = don't care.
- match  out  1  one-cycle pulse: the window or group equals the pattern under the mask.
- not_match  out  1  one-cycle pulse: a verdict was issued and it is a mismatch.
- match_cnt  out  CNT_W  saturating count of match pulses.
- verdict_cnt  out  CNT_W  saturating count of all verdicts.

## Operation
- Reset (sync, rst=1 at an edge):
  - match, not_match, match_cnt and verdict_cnt go to 0.
  - pattern register = PATTERN; mask register = all ones.
  - Bit position counter = 0, shift register = 0, mismatch flag = 0.
  - Fill state = S_FILL.
- Accepted bit: data_valid=1 and pattern_load=0. Bits with data_valid=0 are ignored and internal state holds.
- Bit position p runs 0..LEN-1 within a group or during fill. Bit at p is compared with pattern[LEN-1-p].
- Grouped mode (MODE=0), states S_FILL only:
  - Each accepted bit ORs (data ^ pattern[LEN-1-p]) & mask[LEN-1-p] into the mismatch flag, then p increments.
  - On the accepted bit with p=LEN-1, a verdict is issued: match if the final flag is 0, otherwise not_match. p and the flag then clear.
  - An early mismatch does not shorten the group. The verdict always comes after exactly LEN accepted bits.
- Sliding mode (MODE=1), states S_FILL then S_STREAM:
  - Every accepted bit shifts into a LEN-bit shift register, LSB side; the newest bit is the LSB.
  - In S_FILL, p counts accepted bits. The LEN-th accepted bit moves the state to S_STREAM and issues a verdict.
  - In S_STREAM, every accepted bit issues a verdict: match if ((shift_next ^ pattern) & mask) == 0.
  - Windows overlap. No reset of the window occurs after a match.
- pattern_load=1:
  - Pattern and mask registers take the inputs.
  - p, the flag and the shift register clear. State returns to S_FILL.
  - Any bit presented on that cycle is discarded, even if data_valid=1.
  - No verdict is issued for a group or window that was in flight.
- Counters:
  - verdict_cnt increments on every verdict; match_cnt increments on every match.
  - Both hold at all ones when saturated and never wrap.
- match and not_match are mutually exclusive and never both 1.
- A mask of all zeros makes every verdict a match.

## Timing
- Verdict latency: match/not_match is registered. It is high for exactly the one cycle following the edge that accepted the deciding bit.
- The counters update on the same edge that raises match/not_match, so they are visible in the same cycle as the pulse.
- Back-to-back verdicts:
  - Grouped mode: the minimum spacing is LEN cycles.
  - Sliding mode: pulses can occur on consecutive cycles; each pulse lasts one cycle with no stretching.
- A bit accepted on the edge right after the deciding edge belongs to the next group or window.
- When rst and pattern_load are both 1, rst wins and the pattern register becomes PATTERN.
- A pattern_load on the deciding edge suppresses that verdict, because the bit is discarded.

## Test plan
- Defaults, data_valid=1, stream 0,1,1,1,0,0 -> match=1 in the cycle after the 6th bit, match_cnt=1, verdict_cnt=1, not_match stays 0.
- Defaults, stream 1,0,0,0,0,0,0,1,1,1,0,0:
  - First group: not_match pulses only after bit 6, not after bit 1.
  - Second group: match after bit 12.
  - Final counts: verdict_cnt=2, match_cnt=1.
- Defaults, 0,1,1,1,0,0 interleaved with data_valid=0 gaps of 0-3 cycles -> a single match pulse one cycle after the 6th valid bit, and no pulses during the gaps.
- MODE=1, LEN=4, PATTERN=4'b1011, stream 1,0,1,1,0,1,1 -> match after bits 4 and 7; not_match after bits 5 and 6; verdict_cnt=4.
- Grouped mode, pattern_load after 3 accepted bits with pattern_in=6'b111111 and mask_in=6'b110000, then stream 1,1,0,0,1,0 -> no verdict for the aborted group, then match; the same stream with a leading 0 gives not_match.
- CNT_W=2, seven consecutive matching groups -> match_cnt and verdict_cnt reach 3 and hold. Then a mid-stream rst -> all outputs 0 on the next cycle, and the pattern register returns to PATTERN.
